fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- N, 4, number of requesters, 2..8.
- WIDTH, 8, data width per beat.
- MAX_BURST, 4, maximum beats per grant, 1..16.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock, in, 1, single clock, all state on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- req, in, N, per-requester write request; req[i] high means data_i holds a valid beat.
- data, in, N*WIDTH, packed requester data; requester i is at bits [i*WIDTH +: WIDTH].
- ack, out, N, one-hot-or-zero; ack[i] high means requester i's beat is accepted this cycle.
- gnt, out, N, one-hot-or-zero registered grant vector.
- fifo_wr, out, 1, write strobe to the downstream FIFO.
- fifo_din, out, WIDTH, write data to the downstream FIFO.
- fifo_full, in, 1, downstream FIFO full flag.
- busy, out, 1, high when state is GRANT.
- beat_count, out, 16, total accepted beats; saturates at 16'hFFFF.
REQ-003 Reset SHALL be asynchronous and active-high, and all other ports SHALL be synchronous to the rising edge of clock.

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-005 In IDLE with req != 0, the next edge SHALL select the requester as the first set req bit, searching upward from rr_ptr and wrapping modulo N.
- On that edge: set gnt to the selected one-hot value, set burst_cnt to 0, and enter GRANT.
REQ-006 In IDLE, gnt, ack and fifo_wr SHALL all be 0.
REQ-007 In GRANT with granted index g, the beat-accept condition SHALL be acc = req[g] && !fifo_full, evaluated combinationally in the same cycle.
- When acc is true: fifo_wr = 1, ack[g] = 1, fifo_din = data slice g.
REQ-008 When acc is false, fifo_wr SHALL be 0 and ack SHALL be 0.
- fifo_din SHALL still show data slice g in GRANT, and SHALL be 0 in IDLE.
REQ-009 Each accept SHALL increment burst_cnt; burst_cnt SHALL be 4 bits wide.
REQ-010 GRANT SHALL release to IDLE on the edge where either release condition holds:
- acc is true and burst_cnt == MAX_BURST-1, or
- req[g] == 0.
REQ-011 On release, gnt SHALL clear to 0 and rr_ptr SHALL become (g+1) mod N.
REQ-012 When req[g] is high and fifo_full is high, the FSM SHALL hold GRANT with no accept and no burst_cnt change.
- There is no timeout; the stall is unbounded.
REQ-013 Every re-arbitration SHALL insert exactly one IDLE cycle, so consecutive grants are separated by one bubble.
REQ-014 Requests from requesters other than g SHALL be ignored while in GRANT.
REQ-015 beat_count SHALL increment by 1 on each edge where acc is true, and SHALL hold at 16'hFFFF once reached.
REQ-016 busy SHALL equal (state == GRANT).
REQ-017 A requester SHALL NOT receive ack without a prior gnt, and at most one ack bit SHALL be high in any cycle.
REQ-018 fifo_full rising in the same cycle as a pending beat SHALL block that beat, so no write is issued while full is high.

Reset
REQ-019 While reset is high, outputs SHALL be as follows, independent of clock:
- state = IDLE.
- gnt = 0, ack = 0, fifo_wr = 0, fifo_din = 0.
- busy = 0, beat_count = 0.
- rr_ptr = 0, burst_cnt = 0.
REQ-020 Reset asserted during GRANT SHALL abort the burst immediately, and fifo_wr SHALL drop in that same cycle.
REQ-021 After reset deasserts, the first arbitration SHALL favour requester 0.

Verification
REQ-022 Single requester: req = 4'b0100 held, N=4, MAX_BURST=4, fifo_full = 0.
- Response: gnt = 4'b0100 one cycle after req, then 4 consecutive acks, then 1 IDLE bubble, then re-grant to 2.
- beat_count = 4 after the first burst.
REQ-023 Round robin: req = 4'b1111 held.
- Response: grant order is 0, 1, 2, 3, 0.
- Each grant gives 4 beats; each grant is followed by 1 bubble.
REQ-024 Full stall: grant to requester 1, then fifo_full = 1 for 5 cycles after the 2nd beat.
- Response: no fifo_wr and no ack during the stall; gnt stays 4'b0010.
- The remaining 2 beats complete after full drops.
REQ-025 Early drop: requester 3 granted, then req[3] falls after 1 beat.
- Response: release on that edge and rr_ptr = 0.
- With req = 4'b1001, the next grant goes to 0.
REQ-026 Mid-burst reset: assert reset during the 3rd beat of a burst.
- Response: fifo_wr, gnt and beat_count go to 0 asynchronously.
- After release with req = 4'b1010, the first grant goes to requester 1.
REQ-027 Saturation: force 65537 accepts.
- Response: beat_count = 16'hFFFF and stays there.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST beats into a downstream FIFO, honouring the FIFO full flag.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data,
    output logic [N-1:0]         ack,
    output logic [N-1:0]         gnt,
    output logic                 fifo_wr,
    output logic [WIDTH-1:0]     fifo_din,
    input  logic                 fifo_full,
    output logic                 busy,
    output logic [15:0]          beat_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IW-1:0]   rr_ptr_r;
    logic [IW-1:0]   rr_ptr_nxt_s;
    logic [IW-1:0]   g_r;
    logic [IW-1:0]   g_nxt_s;
    logic [N-1:0]    gnt_r;
    logic [N-1:0]    gnt_nxt_s;
    logic [3:0]      burst_cnt_r;
    logic [3:0]      burst_cnt_nxt_s;
    logic [15:0]     beat_count_r;
    logic [IW-1:0]   pick_s;
    logic            acc_s;
    logic            last_beat_s;

    function automatic logic [N-1:0] one_hot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Walk downward so the lowest offset from ptr wins: first set bit at or after ptr, wrapping.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] ptr);
        logic [IW-1:0] sel;
        int            idx;
        sel = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (r[idx]) begin
                sel = IW'(idx);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Beat acceptance and downstream write path, combinational within the grant cycle.
    always_comb begin
        pick_s      = rr_pick(req, rr_ptr_r);
        acc_s       = 1'b0;
        last_beat_s = (burst_cnt_r == 4'(MAX_BURST - 1));
        ack         = {N{1'b0}};
        fifo_wr     = 1'b0;
        fifo_din    = {WIDTH{1'b0}};
        if (state_r == GRANT) begin
            acc_s    = req[g_r] && !fifo_full;
            fifo_din = data[int'(g_r)*WIDTH +: WIDTH];
            if (acc_s) begin
                fifo_wr = 1'b1;
                ack     = one_hot(g_r);
            end else begin
                fifo_wr = 1'b0;
                ack     = {N{1'b0}};
            end
        end else begin
            acc_s = 1'b0;
        end
    end

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        state_nxt_s     = state_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        g_nxt_s         = g_r;
        gnt_nxt_s       = gnt_r;
        burst_cnt_nxt_s = burst_cnt_r;
        case (state_r)
            IDLE: begin
                if (req != {N{1'b0}}) begin
                    state_nxt_s     = GRANT;
                    g_nxt_s         = pick_s;
                    gnt_nxt_s       = one_hot(pick_s);
                    burst_cnt_nxt_s = 4'd0;
                end else begin
                    gnt_nxt_s = {N{1'b0}};
                end
            end
            GRANT: begin
                // A dropped request or the final beat both hand the pointer past g.
                if (!req[g_r] || (acc_s && last_beat_s)) begin
                    state_nxt_s  = IDLE;
                    gnt_nxt_s    = {N{1'b0}};
                    rr_ptr_nxt_s = (int'(g_r) == N - 1) ? {IW{1'b0}} : g_r + IW'(1);
                end else if (acc_s) begin
                    burst_cnt_nxt_s = burst_cnt_r + 4'd1;
                end else begin
                    burst_cnt_nxt_s = burst_cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = {N{1'b0}};
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {IW{1'b0}};
            g_r         <= {IW{1'b0}};
            gnt_r       <= {N{1'b0}};
            burst_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            g_r         <= g_nxt_s;
            gnt_r       <= gnt_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Saturating count of accepted beats.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_count_r <= 16'h0000;
        end else if (acc_s && (beat_count_r != 16'hFFFF)) begin
            beat_count_r <= beat_count_r + 16'h0001;
        end else begin
            beat_count_r <= beat_count_r;
        end
    end

    assign gnt        = gnt_r;
    assign busy       = (state_r == GRANT);
    assign beat_count = beat_count_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a cycle-level reference model predicts
// accepted beats into a queue that a negedge monitor pops against the DUT.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int MB    = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [N-1:0]         req;
    logic [N*WIDTH-1:0]   data;
    logic [N-1:0]         ack;
    logic [N-1:0]         gnt;
    logic                 fifo_wr;
    logic [WIDTH-1:0]     fifo_din;
    logic                 fifo_full;
    logic                 busy;
    logic [15:0]          beat_count;

    logic                 reset2;
    logic [1:0]           req2 = 2'b11;
    logic [15:0]          data2 = 16'hA55A;
    logic [1:0]           ack2;
    logic [1:0]           gnt2;
    logic                 fifo_wr2;
    logic [7:0]           fifo_din2;
    logic                 fifo_full2 = 1'b0;
    logic                 busy2;
    logic [15:0]          beat_count2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int               stamp;
        int               idx;
        logic [WIDTH-1:0] d;
    } beat_t;
    beat_t exp_q[$];
    beat_t mon_e;
    bit    mon_has;

    bit m_busy;
    bit m_acc;
    int m_g;
    int m_cnt;
    int m_ptr;
    int m_beats;

    always #5 clock = ~clock;

    fifo_wr_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset), .req(req), .data(data), .ack(ack), .gnt(gnt),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full),
        .busy(busy), .beat_count(beat_count)
    );

    fifo_wr_arbiter #(.N(2), .WIDTH(8), .MAX_BURST(16)) dut_sat (
        .clock(clock), .reset(reset2), .req(req2), .data(data2), .ack(ack2), .gnt(gnt2),
        .fifo_wr(fifo_wr2), .fifo_din(fifo_din2), .fifo_full(fifo_full2),
        .busy(busy2), .beat_count(beat_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] gnt_of(input bit b, input int g);
        logic [N-1:0] v;
        v = '0;
        if (b) v[g] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_acc   = 1'b0;
        m_g     = 0;
        m_cnt   = 0;
        m_ptr   = 0;
        m_beats = 0;
        exp_q.delete();
    endtask

    // Advance the reference model across one rising edge.
    task automatic model_edge(input logic [N-1:0] r);
        bit found;
        if (!m_busy) begin
            if (r != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && r[(m_ptr + k) % N]) begin
                        m_g   = (m_ptr + k) % N;
                        found = 1'b1;
                    end
                end
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (!r[m_g] || (m_acc && m_cnt == MB - 1)) begin
            m_busy = 1'b0;
            m_ptr  = (m_g + 1) % N;
        end else if (m_acc) begin
            m_cnt++;
        end
        if (m_acc && m_beats < 65535) m_beats++;
    endtask

    task automatic step(input logic [N-1:0] r, input logic f);
        req       = r;
        fifo_full = f;
        for (int i = 0; i < N; i++) data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        m_acc = m_busy && r[m_g] && !f;
        if (m_acc) exp_q.push_back('{cyc, m_g, data[m_g*WIDTH +: WIDTH]});
        @(posedge clock);
        #1;
        model_edge(r);
        cyc++;
        check("gnt", 32'(gnt), 32'(gnt_of(m_busy, m_g)));
        check("busy", 32'(busy), 32'(m_busy));
        check("beat_count", 32'(beat_count), 32'(m_beats));
    endtask

    task automatic do_reset();
        req       = '0;
        fifo_full = 1'b0;
        reset     = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_wr", 32'(fifo_wr), 32'h0);
        check("rst_din", 32'(fifo_din), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_beats", 32'(beat_count), 32'h0);
        @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    // Monitor: every non-reset cycle is compared against the expected-beat queue.
    always @(negedge clock) begin
        if (!reset) begin
            mon_has = (exp_q.size() > 0) && (exp_q[0].stamp == cyc);
            check("fifo_wr", 32'(fifo_wr), 32'(mon_has));
            if (mon_has) begin
                mon_e = exp_q.pop_front();
                if (fifo_wr) begin
                    check("ack", 32'(ack), 32'(gnt_of(1'b1, mon_e.idx)));
                    check("fifo_din_wr", 32'(fifo_din), 32'(mon_e.d));
                end
            end else begin
                check("ack_quiet", 32'(ack), 32'h0);
                check("fifo_din_hold", 32'(fifo_din),
                      m_busy ? 32'(data[m_g*WIDTH +: WIDTH]) : 32'h0);
            end
        end
    end

    function automatic int sat_exp(input int c);
        int b;
        b = 16 * (c / 17) + (((c % 17) > 0) ? (c % 17) - 1 : 0);
        return (b > 65535) ? 65535 : b;
    endfunction

    initial begin
        int order[$];
        logic [N-1:0] prev;
        logic [N-1:0] r;
        logic         f;
        reset  = 1'b0;
        reset2 = 1'b0;
        model_reset();
        #1;
        fork
            begin
                do_reset();
                // Single requester 2: grant, four beats, one bubble, re-grant.
                for (int i = 0; i < 5; i++) step(4'b0100, 1'b0);
                check("single_beats4", 32'(beat_count), 32'd4);
                check("single_bubble", 32'(gnt), 32'h0);
                step(4'b0100, 1'b0);
                check("single_regrant", 32'(gnt), 32'(4'b0100));
                for (int i = 0; i < 6; i++) step(4'b0100, 1'b0);

                // Round robin with all requesting.
                do_reset();
                prev = '0;
                for (int i = 0; i < 22; i++) begin
                    step(4'b1111, 1'b0);
                    if (gnt != '0 && prev == '0) order.push_back($clog2(gnt));
                    prev = gnt;
                end
                check("rr_count", 32'(order.size()), 32'd5);
                for (int k = 0; k < 5 && k < order.size(); k++)
                    check("rr_order", 32'(order[k]), 32'(k % 4));

                // Full stall after the second beat of requester 1.
                do_reset();
                for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
                for (int i = 0; i < 5; i++) step(4'b0010, 1'b1);
                check("stall_gnt", 32'(gnt), 32'(4'b0010));
                check("stall_beats", 32'(beat_count), 32'd2);
                step(4'b0010, 1'b0);
                step(4'b0010, 1'b0);
                check("stall_done_gnt", 32'(gnt), 32'h0);
                check("stall_done_beats", 32'(beat_count), 32'd4);

                // Early drop by requester 3, pointer wraps to 0.
                do_reset();
                step(4'b1000, 1'b0);
                step(4'b1000, 1'b0);
                step(4'b0001, 1'b0);
                check("drop_release", 32'(gnt), 32'h0);
                step(4'b1001, 1'b0);
                check("drop_next0", 32'(gnt), 32'(4'b0001));
                step(4'b1001, 1'b0);

                // Reset in the middle of the third beat.
                do_reset();
                for (int i = 0; i < 3; i++) step(4'b0100, 1'b0);
                #2;
                check("mid_wr_before", 32'(fifo_wr), 32'h1);
                reset = 1'b1;
                #1;
                check("mid_wr", 32'(fifo_wr), 32'h0);
                check("mid_gnt", 32'(gnt), 32'h0);
                check("mid_beats", 32'(beat_count), 32'h0);
                check("mid_ack", 32'(ack), 32'h0);
                @(posedge clock);
                #1;
                model_reset();
                reset = 1'b0;
                step(4'b1010, 1'b0);
                check("mid_first1", 32'(gnt), 32'(4'b0010));
                for (int i = 0; i < 10; i++) step(4'b1010, 1'b0);

                // Randomised traffic with sticky requests and a random full flag.
                do_reset();
                r = '0;
                for (int i = 0; i < 800; i++) begin
                    if ($urandom_range(3, 0) == 0) r = N'($urandom);
                    f = ($urandom_range(3, 0) == 0);
                    step(r, f);
                end
                step('0, 1'b0);
                check("queue_drained", 32'(exp_q.size()), 32'h0);
            end
            begin
                int c;
                c = 0;
                reset2 = 1'b1;
                @(posedge clock);
                #1;
                reset2 = 1'b0;
                while (c < 69700) begin
                    @(posedge clock);
                    #1;
                    c++;
                    if (c == 1000 || c == 69630 || c == 69631 || c == 69700) begin
                        check("sat_beats", 32'(beat_count2), 32'(sat_exp(c)));
                        check("sat_busy", 32'(busy2), 32'((c % 17) != 0));
                    end
                end
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
